// File: rtl/ping_pong_pkg.sv
// Shared types and helpers for the ping-pong buffer read-side controller.
package ping_pong_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_t;

  // Word-address width inside one bank; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ping_pong_stream_reader_if.sv
// Buffer read port plus outgoing stream of the ping-pong reader.
// Stream handshake: a word transfers on a clock edge where m_valid & m_ready;
// once m_valid is high it stays high, with m_data/m_last frozen, until that transfer.
interface ping_pong_stream_reader_if #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16
);
  localparam int ADDR_W = ping_pong_pkg::addr_width(DEPTH);

  logic                  rd_en;
  logic                  rd_bank;
  logic [ADDR_W-1:0]     rd_addr;
  logic [BIT_LENGTH-1:0] rd_data;
  logic                  m_valid;
  logic [BIT_LENGTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output rd_en, rd_bank, rd_addr, m_valid, m_data, m_last,
    input  rd_data, m_ready
  );

  modport slave (
    input  rd_en, rd_bank, rd_addr, m_valid, m_data, m_last,
    output rd_data, m_ready
  );
endinterface

// File: rtl/stream_skid_fifo.sv
// Two-entry fall-through FIFO: an arriving word is presented the same cycle
// when the FIFO is empty, otherwise it queues behind the stored head.
module stream_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         head;
  logic         tail;
  logic         stored;
  logic         pop;
  logic         push_mem;
  logic         pop_mem;

  assign stored    = (count != 2'd0);
  assign out_valid = stored | in_valid;
  assign out_data  = stored ? mem[head] : in_data;
  assign pop       = out_valid & out_ready;
  assign pop_mem   = pop & stored;
  // An arriving word consumed directly on the bypass path is never stored.
  assign push_mem  = in_valid & ~(pop & ~stored);

  always_ff @(posedge clk) begin
    if (push_mem) mem[tail] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push_mem) tail <= ~tail;
      if (pop_mem)  head <= ~head;
      count <= count + {1'b0, push_mem} - {1'b0, pop_mem};
    end
  end
endmodule

// File: rtl/ping_pong_stream_reader.sv
// Streams each announced bank of a two-bank ping-pong buffer, banks taken in
// strict 0,1,0,1 order, and hands a bank back once its last word is accepted.
module ping_pong_stream_reader
  import ping_pong_pkg::*;
#(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = addr_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_done,
  input  logic                      wr_done_bank,
  input  logic [ADDR_W:0]           wr_done_len,
  output logic [1:0]                bank_free,
  ping_pong_stream_reader_if.master bus,
  output logic                      busy,
  output logic                      err,
  output rd_state_t                 fsm_state
);
  rd_state_t         state;
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic [ADDR_W:0]   len [2];
  logic              cur_bank;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight;
  logic              inflight_last;

  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [BIT_LENGTH:0] fifo_out;

  logic              credit;
  logic              release_hs;
  logic              start;
  logic              chain;
  logic              rd_en;
  logic              issue_bank;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W:0]   last_idx;
  logic              issue_last;
  logic              wr_ok;

  assign credit     = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;
  assign release_hs = (state == DRAIN) & bus.m_valid & bus.m_ready & bus.m_last;
  assign start      = (state == IDLE) & full[cur_bank] & credit;
  // Starting the next bank on the release cycle keeps back-to-back banks gap-free.
  assign chain      = release_hs & full[~cur_bank] & credit;

  always_comb begin
    issue_bank = (state == DRAIN) ? ~cur_bank : cur_bank;
    issue_addr = (state == STREAM) ? addr_q : '0;
    rd_en      = start | chain | ((state == STREAM) & credit);
    last_idx   = len[issue_bank] - (ADDR_W+1)'(1);
    issue_last = (issue_addr == last_idx[ADDR_W-1:0]);
  end

  assign wr_ok = wr_done & ~full[wr_done_bank] & (wr_done_len != '0) &
                 (wr_done_len <= (ADDR_W+1)'(DEPTH));

  // Release and acceptance never touch the same bit: acceptance needs the bank empty.
  always_comb begin
    full_next = full;
    if (release_hs) full_next[cur_bank] = 1'b0;
    if (wr_ok)      full_next[wr_done_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      full          <= 2'b00;
      len[0]        <= '0;
      len[1]        <= '0;
      cur_bank      <= 1'b0;
      addr_q        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err           <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en & issue_last;
      full          <= full_next;
      if (wr_ok) len[wr_done_bank] <= wr_done_len;
      if (wr_done & ~wr_ok) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= ADDR_W'(1);
            state  <= issue_last ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (rd_en) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (release_hs) begin
            cur_bank <= ~cur_bank;
            if (chain) begin
              addr_q <= ADDR_W'(1);
              state  <= issue_last ? DRAIN : STREAM;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_skid_fifo #(.W(BIT_LENGTH + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   ({inflight_last, bus.rd_data}),
    .out_valid (fifo_valid),
    .out_data  (fifo_out),
    .out_ready (bus.m_ready),
    .count     (fifo_count)
  );

  assign bus.rd_en   = rd_en;
  assign bus.rd_bank = issue_bank;
  assign bus.rd_addr = issue_addr;
  assign bus.m_valid = fifo_valid;
  assign bus.m_data  = fifo_out[BIT_LENGTH-1:0];
  assign bus.m_last  = fifo_out[BIT_LENGTH];

  assign bank_free = ~full;
  assign busy      = (state != IDLE) | (fifo_count != 2'd0) | inflight;
  assign fsm_state = state;
endmodule

// File: tb/tb_ping_pong_stream_reader.sv
// Bench for ping_pong_stream_reader: error table, hand-timed sequences and a
// randomized run scored against a bank-level model of the buffer and stream.
module tb_ping_pong_stream_reader;
  import ping_pong_pkg::*;

  localparam int BL     = 64;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int W      = BL + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_done = 1'b0;
  logic              wr_done_bank = 1'b0;
  logic [ADDR_W:0]   wr_done_len = '0;
  logic [1:0]        bank_free;
  logic              busy;
  logic              err;
  rd_state_t         fsm_state;

  ping_pong_stream_reader_if #(.BIT_LENGTH(BL), .DEPTH(DEPTH)) bus ();

  ping_pong_stream_reader #(.BIT_LENGTH(BL), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_done      (wr_done),
    .wr_done_bank (wr_done_bank),
    .wr_done_len  (wr_done_len),
    .bank_free    (bank_free),
    .bus          (bus),
    .busy         (busy),
    .err          (err),
    .fsm_state    (fsm_state)
  );

  // Buffer with one cycle of read latency; junk on idle cycles.
  logic [BL-1:0] mem [2][DEPTH];
  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? mem[bus.rd_bank][bus.rd_addr] : {$urandom, $urandom};

  // ---------------- scoreboard state ----------------
  int nvec  = 0;
  int nfail = 0;
  logic [W-1:0]  exp_q[$];
  logic [BL-1:0] snap [2][DEPTH];
  int            snap_len [2];
  logic [1:0]    model_full = 2'b00;
  logic [1:0]    model_pending = 2'b00;
  logic          model_next = 1'b0;
  logic          model_cons = 1'b0;
  logic          model_err = 1'b0;
  int            outstanding = 0;
  logic          prev_stall = 1'b0;
  logic [BL-1:0] prev_data;
  logic          prev_last;
  logic          check_en = 1'b0;
  logic [W-1:0]  mon_e;
  logic          mon_hs;
  logic          mon_rel;
  logic [1:0]    mon_free;
  int            ready_mode = 0;
  int            pat_i = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      mon_free = ~model_full;
      check("bank_free", bank_free, mon_free);
      check("err", err, model_err);
      check("outstanding_le_2", (outstanding + int'(bus.rd_en)) <= 2, 1'b1);
      if (prev_stall) begin
        check("stall_valid", bus.m_valid, 1'b1);
        check("stall_data", bus.m_data, prev_data);
        check("stall_last", bus.m_last, prev_last);
      end
      mon_hs  = bus.m_valid && bus.m_ready;
      mon_rel = 1'b0;
      if (mon_hs) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("beat_data", bus.m_data, mon_e[BL-1:0]);
          check("beat_last", bus.m_last, mon_e[BL]);
          mon_rel = mon_e[BL];
        end
      end
      prev_stall  = bus.m_valid && !bus.m_ready;
      prev_data   = bus.m_data;
      prev_last   = bus.m_last;
      outstanding = outstanding + int'(bus.rd_en) - int'(mon_hs);

      if (rst) begin
        exp_q.delete();
        model_full = 2'b00; model_pending = 2'b00;
        model_next = 1'b0;  model_cons = 1'b0; model_err = 1'b0;
        outstanding = 0;    prev_stall = 1'b0;
      end else begin
        // Announcement judged against bank state before any release on this edge.
        if (wr_done) begin
          if (!model_full[wr_done_bank] && wr_done_len >= 1 && wr_done_len <= DEPTH) begin
            model_full[wr_done_bank] = 1'b1;
            model_pending[wr_done_bank] = 1'b1;
            snap_len[wr_done_bank] = int'(wr_done_len);
            for (int i = 0; i < int'(wr_done_len); i++) snap[wr_done_bank][i] = mem[wr_done_bank][i];
          end else begin
            model_err = 1'b1;
          end
        end
        if (mon_rel) begin
          model_full[model_cons] = 1'b0;
          model_cons = ~model_cons;
        end
        while (model_pending[model_next]) begin
          for (int i = 0; i < snap_len[model_next]; i++)
            exp_q.push_back({(i == snap_len[model_next] - 1), snap[model_next][i]});
          model_pending[model_next] = 1'b0;
          model_next = ~model_next;
        end
      end
    end
  end

  // Downstream ready: 0 = held by the main sequence, 1 = random, 2 = 1,0,0 repeating.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) bus.m_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 2) begin
      bus.m_ready = (pat_i % 3 == 0);
      pat_i++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input int b, input int n);
    for (int i = 0; i < n; i++) mem[b][i] = {$urandom, $urandom};
  endtask

  task automatic pulse_done(input int b, input int n);
    wr_done      = 1'b1;
    wr_done_bank = b[0];
    wr_done_len  = n[ADDR_W:0];
    tick();
    wr_done = 1'b0;
  endtask

  task automatic do_reset();
    wr_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy || model_pending != 2'b00) && k < limit) begin
      tick();
      k++;
    end
    nvec++;
    if (k >= limit) begin
      nfail++;
      $display("FAIL %s: still busy after %0d cycles, %0d words expected", name, k, exp_q.size());
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit         pre;
    int         bank;
    int         len;
    logic       exp_err;
    logic [1:0] exp_free;
  } err_vec_t;

  err_vec_t tbl [8];
  int       b;
  int       r;
  int       n;
  int       beats;
  int       k;

  initial begin
    tbl[0] = '{pre: 0, bank: 0, len: 4,  exp_err: 1'b0, exp_free: 2'b10};
    tbl[1] = '{pre: 0, bank: 1, len: 16, exp_err: 1'b0, exp_free: 2'b01};
    tbl[2] = '{pre: 0, bank: 0, len: 0,  exp_err: 1'b1, exp_free: 2'b11};
    tbl[3] = '{pre: 0, bank: 0, len: 17, exp_err: 1'b1, exp_free: 2'b11};
    tbl[4] = '{pre: 0, bank: 1, len: 31, exp_err: 1'b1, exp_free: 2'b11};
    tbl[5] = '{pre: 1, bank: 0, len: 4,  exp_err: 1'b1, exp_free: 2'b10};
    tbl[6] = '{pre: 1, bank: 1, len: 1,  exp_err: 1'b0, exp_free: 2'b00};
    tbl[7] = '{pre: 0, bank: 0, len: 1,  exp_err: 1'b0, exp_free: 2'b10};

    bus.m_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_m_valid", bus.m_valid, 1'b0);
    check("reset_rd_en", bus.rd_en, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_bank_free", bank_free, 2'b11);
    check("reset_state", fsm_state, IDLE);
    check_en = 1'b1;
    rst = 1'b0;
    tick();

    // Announcement acceptance table, stream stalled so banks stay full.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (tbl[i].pre) begin
        fill_mem(0, 4);
        pulse_done(0, 4);
      end
      if (!model_full[tbl[i].bank]) fill_mem(tbl[i].bank, DEPTH);
      pulse_done(tbl[i].bank, tbl[i].len);
      check("tbl_err", err, tbl[i].exp_err);
      check("tbl_bank_free", bank_free, tbl[i].exp_free);
    end

    // Single bank: exact read/beat timing.
    do_reset();
    bus.m_ready = 1'b1;
    fill_mem(0, 4);
    pulse_done(0, 4);
    for (int i = 0; i < 4; i++) begin
      check("single_rd_en", bus.rd_en, 1'b1);
      check("single_rd_addr", bus.rd_addr, i[ADDR_W-1:0]);
      check("single_rd_bank", bus.rd_bank, 1'b0);
      check("single_m_valid", bus.m_valid, i != 0);
      tick();
    end
    check("single_rd_done", bus.rd_en, 1'b0);
    check("single_last_valid", bus.m_valid, 1'b1);
    check("single_last_flag", bus.m_last, 1'b1);
    tick();
    check("single_free_after", bank_free, 2'b11);
    check("single_idle_valid", bus.m_valid, 1'b0);
    check("single_idle_busy", busy, 1'b0);

    // Back-to-back full banks: 32 beats without a gap.
    do_reset();
    fill_mem(0, DEPTH);
    fill_mem(1, DEPTH);
    pulse_done(0, DEPTH);
    pulse_done(1, DEPTH);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      check("b2b_valid", bus.m_valid, 1'b1);
      check("b2b_last", bus.m_last, (i == DEPTH - 1) || (i == 2 * DEPTH - 1));
      tick();
    end
    check("b2b_end_valid", bus.m_valid, 1'b0);
    check("b2b_end_state", fsm_state, IDLE);

    // Backpressure on bank 0, which must be the next bank after the pair above.
    ready_mode = 2;
    fill_mem(0, 8);
    pulse_done(0, 8);
    wait_idle("backpressure_idle", 200);
    ready_mode = 0;
    bus.m_ready = 1'b1;

    // Bank 1 announced first is held until bank 0 has streamed.
    do_reset();
    ready_mode = 1;
    fill_mem(1, 5);
    pulse_done(1, 5);
    repeat (3) tick();
    check("order_held_rd_en", bus.rd_en, 1'b0);
    check("order_held_state", fsm_state, IDLE);
    fill_mem(0, 3);
    pulse_done(0, 3);
    wait_idle("order_idle", 200);
    check("order_err", err, 1'b0);
    ready_mode = 0;
    bus.m_ready = 1'b1;

    // Reset after the third accepted beat of an 8-word bank.
    do_reset();
    fill_mem(0, 8);
    pulse_done(0, 8);
    beats = 0;
    k = 0;
    while (beats < 3 && k < 20) begin
      if (bus.m_valid && bus.m_ready) beats++;
      tick();
      k++;
    end
    check("rst_mid_beats", beats, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", bus.m_valid, 1'b0);
    check("rst_mid_free", bank_free, 2'b11);
    check("rst_mid_busy", busy, 1'b0);
    fill_mem(0, 2);
    pulse_done(0, 2);
    wait_idle("rst_fresh_idle", 50);

    // Randomized traffic, including occasional bad announcements.
    do_reset();
    ready_mode = 1;
    for (int it = 0; it < 120; it++) begin
      repeat ($urandom_range(0, 4)) tick();
      b = $urandom_range(0, 1);
      r = $urandom_range(0, 11);
      if (r == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : DEPTH + 1;
        pulse_done(b, n);
      end else if (!model_full[b]) begin
        n = $urandom_range(1, DEPTH);
        fill_mem(b, n);
        pulse_done(b, n);
      end else if (r == 1) begin
        pulse_done(b, 4);
      end
    end
    if (model_pending != 2'b00) begin
      b = int'(model_next);
      fill_mem(b, 1);
      pulse_done(b, 1);
    end
    wait_idle("random_idle", 2000);
    check("final_busy", busy, 1'b0);
    check("final_state", fsm_state, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
